// File: rtl/mem_ctrl_rr_if.sv
// rtl/mem_ctrl_rr_if.sv - requester-side request/response bus of mem_ctrl_rr
// Port p owns slice p of every packed req_* vector; resp_data is shared by all ports.
interface mem_ctrl_rr_if #(
   parameter int NPORT      = 2,
   parameter int LINE_BYTES = 16
);
   localparam int NB_W = $clog2(LINE_BYTES) + 1;

   logic [NPORT-1:0]              req_valid;
   logic [NPORT-1:0]              req_wr;
   logic [NPORT*32-1:0]           req_addr;
   logic [NPORT*NB_W-1:0]         req_nbytes;
   logic [NPORT*LINE_BYTES*8-1:0] req_wdata;
   logic [NPORT-1:0]              resp_valid;
   logic [LINE_BYTES*8-1:0]       resp_data;

   modport master (
      output req_valid, req_wr, req_addr, req_nbytes, req_wdata,
      input  resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_nbytes, req_wdata,
      output resp_valid, resp_data
   );
endinterface

// File: rtl/mem_ctrl_rr.sv
// rtl/mem_ctrl_rr.sv - round-robin byte-serial RAM/IO access controller
// Optional MEMCTL_PERF_EN adds perf_xfer_cnt / perf_stall_cnt outputs.
module mem_ctrl_rr #(
   parameter int NPORT      = 2,
   parameter int LINE_BYTES = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        flush_in,
`ifdef MEMCTL_PERF_EN
   output logic [31:0] perf_xfer_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   mem_ctrl_rr_if.slave bus
);
   localparam int NB_W = $clog2(LINE_BYTES) + 1;
   localparam int KW   = $clog2(LINE_BYTES);
   localparam int PW   = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int LW   = LINE_BYTES * 8;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [PW-1:0]    rr, grant, port_r;
   logic             grant_ok;
   logic [PW:0]      arb_s;
   logic [NPORT-1:0] last_done, cand, resp_oh;
   logic             wr_r;
   logic [31:0]      addr_r, cur_addr;
   logic [NB_W-1:0]  n_r, req_n, n_clamp;
   logic [KW-1:0]    k_r, k_m1, last_idx;
   logic [LW-1:0]    wdata_r, data_r;
   logic             stall, last_byte, take;

   // First valid port at or after rr; the port that just completed sits out one cycle.
   always_comb begin
      cand     = bus.req_valid & ~last_done;
      grant    = rr;
      grant_ok = 1'b0;
      arb_s    = '0;
      for (int i = NPORT - 1; i >= 0; i--) begin
         arb_s = {1'b0, rr} + (PW+1)'(i);
         if (arb_s >= (PW+1)'(NPORT))
            arb_s = arb_s - (PW+1)'(NPORT);
         if (cand[arb_s[PW-1:0]]) begin
            grant    = arb_s[PW-1:0];
            grant_ok = 1'b1;
         end
      end
   end

   assign req_n     = bus.req_nbytes[grant*NB_W +: NB_W];
   assign n_clamp   = (req_n == '0 || req_n > NB_W'(LINE_BYTES)) ? NB_W'(LINE_BYTES) : req_n;
   assign take      = !flush_in && grant_ok;
   assign cur_addr  = addr_r + {{(32-KW){1'b0}}, k_r};
   assign stall     = wr_r && (cur_addr[17:16] == 2'b11) && io_buffer_full;
   assign last_byte = ({1'b0, k_r} == n_r - 1'b1);
   assign k_m1      = k_r - 1'b1;
   assign last_idx  = KW'(n_r - 1'b1);

   always_comb begin
      state_nxt = state;
      mem_a     = '0;
      mem_dout  = '0;
      mem_wr    = 1'b0;
      resp_oh   = '0;
      case (state)
         IDLE: if (take) state_nxt = ISSUE;
         ISSUE: begin
            mem_a    = cur_addr;
            mem_dout = wdata_r[{k_r, 3'b000} +: 8];
            mem_wr   = wr_r && !stall && rdy_in;
            // Committed stores ignore flush; reads are abandoned.
            if (flush_in && !wr_r)
               state_nxt = IDLE;
            else if (!stall && last_byte)
               state_nxt = wr_r ? DONE : DRAIN;
         end
         DRAIN: state_nxt = flush_in ? IDLE : DONE;
         DONE: begin
            state_nxt = IDLE;
            if (wr_r || !flush_in)
               resp_oh[port_r] = rdy_in;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state     <= IDLE;
         rr        <= '0;
         port_r    <= '0;
         last_done <= '0;
         wr_r      <= 1'b0;
         addr_r    <= '0;
         n_r       <= '0;
         k_r       <= '0;
         wdata_r   <= '0;
         data_r    <= '0;
      end else if (rdy_in) begin
         state     <= state_nxt;
         last_done <= resp_oh;
         case (state)
            IDLE: if (take) begin
               port_r  <= grant;
               rr      <= (grant == PW'(NPORT - 1)) ? '0 : grant + 1'b1;
               wr_r    <= bus.req_wr[grant];
               addr_r  <= bus.req_addr[grant*32 +: 32];
               n_r     <= n_clamp;
               wdata_r <= bus.req_wdata[grant*LW +: LW];
               data_r  <= '0;
               k_r     <= '0;
            end
            ISSUE: begin
               // mem_din carries the byte addressed one cycle earlier.
               if (!wr_r && k_r != '0)
                  data_r[{k_m1, 3'b000} +: 8] <= mem_din;
               if (!stall && !last_byte)
                  k_r <= k_r + 1'b1;
            end
            DRAIN: data_r[{last_idx, 3'b000} +: 8] <= mem_din;
            default: ;
         endcase
      end
   end

   assign bus.resp_valid = resp_oh;
   assign bus.resp_data  = data_r;

`ifdef MEMCTL_PERF_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         perf_xfer_cnt  <= '0;
         perf_stall_cnt <= '0;
      end else if (rdy_in && state == ISSUE) begin
         if (stall)
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
         else
            perf_xfer_cnt  <= perf_xfer_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_mem_ctrl_rr.sv
// tb/tb_mem_ctrl_rr.sv - directed and randomized bench for mem_ctrl_rr
// Reference: byte-array memory image and per-port request bookkeeping.
module tb_mem_ctrl_rr;
   localparam int NPORT = 2;
   localparam int LB    = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        io_full = 1'b0;
   logic        flush = 1'b0;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
`ifdef MEMCTL_PERF_EN
   logic [31:0] perf_xfer, perf_stall, px0, ps0;
`endif

   mem_ctrl_rr_if #(.NPORT(NPORT), .LINE_BYTES(LB)) bus();

   mem_ctrl_rr #(.NPORT(NPORT), .LINE_BYTES(LB)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_full), .flush_in(flush),
`ifdef MEMCTL_PERF_EN
      .perf_xfer_cnt(perf_xfer), .perf_stall_cnt(perf_stall),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [7:0] ram  [0:262143] = '{default: 8'h00};
   logic [7:0] refm [0:262143] = '{default: 8'h00};

   // RAM answers one cycle after the address and freezes with rdy.
   always @(posedge clk) begin
      if (!rst && rdy) begin
         if (mem_wr) ram[mem_a[17:0]] = mem_dout;
         mem_din <= ram[mem_a[17:0]];
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int clampn(input logic [4:0] nb);
      return (nb == 0 || nb > LB) ? LB : int'(nb);
   endfunction

   function automatic logic [127:0] exp_read(input logic [31:0] a, input logic [4:0] nb);
      logic [127:0] r = '0;
      logic [31:0]  ai;
      for (int i = 0; i < clampn(nb); i++) begin
         ai = a + i;
         r[i*8 +: 8] = refm[ai[17:0]];
      end
      return r;
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [4:0] nb, input logic [127:0] wd);
      logic [31:0] ai;
      for (int i = 0; i < clampn(nb); i++) begin
         ai = a + i;
         refm[ai[17:0]] = wd[i*8 +: 8];
      end
   endfunction

   logic         tr_wr [0:63];
   logic [31:0]  tr_a  [0:63];
   logic [7:0]   tr_d  [0:63];
   logic [1:0]   tr_rv [0:63];
   bit           fl_s  [0:63];
   bit           io_s  [0:63];
   int           first_resp;
   logic [127:0] cap;

   // Cycle 0 is the cycle the request is raised; schedules index the same cycles.
   task automatic txn(input int p, input bit wr, input logic [31:0] a, input logic [4:0] nb,
                      input logic [127:0] wd, input int ncyc);
      bit dropped = 0;
      first_resp = -1;
      cap = '0;
      bus.req_wr[p]              = wr;
      bus.req_addr[p*32 +: 32]   = a;
      bus.req_nbytes[p*5 +: 5]   = nb;
      bus.req_wdata[p*128 +: 128] = wd;
      bus.req_valid[p]           = 1'b1;
      for (int t = 0; t < ncyc; t++) begin
         flush   = fl_s[t];
         io_full = io_s[t];
         if (dropped) bus.req_valid[p] = 1'b0;
         #1;
         tr_wr[t] = mem_wr;
         tr_a[t]  = mem_a;
         tr_d[t]  = mem_dout;
         tr_rv[t] = bus.resp_valid;
         if (bus.resp_valid != 0 && first_resp < 0) begin
            first_resp = t;
            cap = bus.resp_data;
         end
         if (bus.resp_valid[p] || (fl_s[t] && !wr)) dropped = 1;
         @(posedge clk); #1;
      end
      bus.req_valid = '0;
      flush = 1'b0;
      io_full = 1'b0;
      for (int t = 0; t < 64; t++) begin
         fl_s[t] = 0;
         io_s[t] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   logic [31:0]  r_addr [NPORT];
   logic [4:0]   r_nb   [NPORT];
   bit           r_wr   [NPORT];
   logic [127:0] r_wd   [NPORT];
   bit           act    [NPORT];
   int           wait_c [NPORT];
   int           others [NPORT];

   initial begin
      int nresp, sel, done_cnt, cyc, bad, p, wsum;
      bit timeout;
      logic [1:0] rv, anyrv;
      logic [127:0] wd;

      bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0;
      bus.req_nbytes = '0; bus.req_wdata = '0;
      for (int t = 0; t < 64; t++) begin fl_s[t] = 0; io_s[t] = 0; end

      repeat (3) @(posedge clk);
      #1;
      check("rst_bus", {mem_a, mem_dout, mem_wr, bus.resp_valid}, '0);
      check("rst_data", bus.resp_data, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Seed 0x100 with 11,22,33,44 through the DUT itself.
      txn(1, 1, 32'h100, 5'd4, 128'h44332211, 8);
      model_write(32'h100, 5'd4, 128'h44332211);
      check("seed_ram", {ram[18'h103], ram[18'h102], ram[18'h101], ram[18'h100]}, 32'h44332211);

      txn(0, 0, 32'h100, 5'd4, '0, 10);
      check("t1_lat", first_resp, 6);
      check("t1_rv", tr_rv[6], 2'b01);
      check("t1_data", cap, 128'h44332211);

      txn(1, 1, 32'h200, 5'd2, 128'hBEEF, 6);
      model_write(32'h200, 5'd2, 128'hBEEF);
      check("t2_wr", {tr_wr[0], tr_wr[1], tr_wr[2], tr_wr[3]}, 4'b0110);
      check("t2_a", {tr_a[1], tr_a[2]}, {32'h200, 32'h201});
      check("t2_dout", {tr_d[1], tr_d[2]}, 16'hEFBE);
      check("t2_lat", first_resp, 3);
      check("t2_rv", tr_rv[3], 2'b10);
      check("t2_ram", {ram[18'h201], ram[18'h200]}, 16'hBEEF);

      bus.req_wr = '0;
      bus.req_addr = {32'h200, 32'h100};
      bus.req_nbytes = {5'd4, 5'd4};
      bus.req_valid = 2'b11;
      nresp = 0;
      for (int t = 0; t < 200 && nresp < 6; t++) begin
         #1;
         if (bus.resp_valid != 0) begin
            check("t3_alt", bus.resp_valid, (nresp % 2 == 0) ? 2'b01 : 2'b10);
            check("t3_data", bus.resp_data,
                  bus.resp_valid[0] ? exp_read(32'h100, 5'd4) : exp_read(32'h200, 5'd4));
            nresp++;
         end
         @(posedge clk); #1;
      end
      check("t3_count", nresp, 6);
      bus.req_valid = '0;
      repeat (3) @(posedge clk);
      #1;

`ifdef MEMCTL_PERF_EN
      px0 = perf_xfer; ps0 = perf_stall;
`endif
      io_s[1] = 1; io_s[2] = 1; io_s[3] = 1;
      txn(0, 1, 32'h30000, 5'd1, 128'h5A, 8);
      model_write(32'h30000, 5'd1, 128'h5A);
      check("t4_wr", {tr_wr[1], tr_wr[2], tr_wr[3], tr_wr[4]}, 4'b0001);
      check("t4_a", {tr_a[1], tr_a[4]}, {32'h30000, 32'h30000});
      check("t4_lat", first_resp, 5);
`ifdef MEMCTL_PERF_EN
      check("t4_perf", {perf_xfer - px0, perf_stall - ps0}, {32'd1, 32'd3});
`endif

      fl_s[5] = 1;
      txn(1, 0, 32'h400, 5'd0, '0, 12);
      anyrv = '0;
      for (int t = 0; t < 12; t++) anyrv = anyrv | tr_rv[t];
      check("t5_noresp", anyrv, 2'b00);
      check("t5_a", {tr_a[5], tr_a[6]}, {32'h404, 32'h0});
      txn(0, 0, 32'h100, 5'd4, '0, 10);
      check("t5_next_lat", first_resp, 6);
      check("t5_next_data", cap, exp_read(32'h100, 5'd4));

`ifdef MEMCTL_PERF_EN
      px0 = perf_xfer;
`endif
      fl_s[2] = 1;
      txn(1, 1, 32'h500, 5'd4, 128'hCAFEF00D, 8);
      model_write(32'h500, 5'd4, 128'hCAFEF00D);
      wsum = 0;
      for (int t = 1; t <= 4; t++) wsum += int'(tr_wr[t]);
      check("t6_bytes", wsum, 4);
      check("t6_lat", first_resp, 5);
`ifdef MEMCTL_PERF_EN
      check("t6_perf", perf_xfer - px0, 32'd4);
`endif

      for (int q = 0; q < NPORT; q++) begin act[q] = 0; wait_c[q] = 0; others[q] = 0; end
      done_cnt = 0; cyc = 0; timeout = 0;
      while ((done_cnt < 80 || act[0] || act[1]) && cyc < 20000 && !timeout) begin
         rdy     = ($urandom_range(0, 9) != 0);
         io_full = ($urandom_range(0, 3) == 0);
         for (int q = 0; q < NPORT; q++) begin
            if (!act[q]) begin
               if (bus.req_valid[q]) bus.req_valid[q] = 1'b0;
               else if (done_cnt < 80 && $urandom_range(0, 2) == 0) begin
                  sel = $urandom_range(0, 9);
                  r_wr[q]   = ($urandom_range(0, 1) == 1);
                  r_addr[q] = (sel < 6) ? 32'($urandom_range(0, 511)) :
                              (sel < 8) ? 32'h3FFE0 + 32'($urandom_range(0, 31)) :
                                          32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                  r_nb[q]   = 5'($urandom_range(0, 31));
                  r_wd[q]   = {$urandom, $urandom, $urandom, $urandom};
                  bus.req_wr[q]               = r_wr[q];
                  bus.req_addr[q*32 +: 32]    = r_addr[q];
                  bus.req_nbytes[q*5 +: 5]    = r_nb[q];
                  bus.req_wdata[q*128 +: 128] = r_wd[q];
                  bus.req_valid[q] = 1'b1;
                  act[q] = 1; wait_c[q] = 0; others[q] = 0;
               end
            end
         end
         #1;
         rv = bus.resp_valid;
         if (rv != 0) begin
            check("rnd_onehot", $onehot(rv), 1'b1);
            p = rv[1] ? 1 : 0;
            check("rnd_req", act[p], 1'b1);
            check("rnd_fair", others[p] <= NPORT - 1, 1'b1);
            if (r_wr[p]) model_write(r_addr[p], r_nb[p], r_wd[p]);
            else check("rnd_rdata", bus.resp_data, exp_read(r_addr[p], r_nb[p]));
            for (int q = 0; q < NPORT; q++) if (q != p && act[q]) others[q]++;
            act[p] = 0;
            done_cnt++;
         end
         for (int q = 0; q < NPORT; q++) begin
            if (act[q]) wait_c[q]++;
            if (act[q] && wait_c[q] > 600) begin
               check("rnd_timeout", wait_c[q], 0);
               timeout = 1;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("rnd_done", done_cnt >= 80, 1'b1);
      rdy = 1'b1; io_full = 1'b0;
      bus.req_valid = '0;
      repeat (4) @(posedge clk);
      #1;

      // Reset in the third byte cycle: bytes 0 and 1 are already in RAM.
      wd = {$urandom, $urandom, $urandom, $urandom};
      bus.req_wr[0] = 1'b1;
      bus.req_addr[31:0] = 32'h600;
      bus.req_nbytes[4:0] = 5'd8;
      bus.req_wdata[127:0] = wd;
      bus.req_valid[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mr_pre", {mem_wr, mem_a}, {1'b1, 32'h602});
      rst = 1'b1;
      #1;
      check("mr_out", {mem_wr, mem_a, mem_dout, bus.resp_valid}, '0);
      bus.req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_write(32'h600, 5'd2, wd);
      repeat (2) @(posedge clk);
      #1;

      bad = 0;
      for (int i = 0; i < 262144; i++) if (ram[i] !== refm[i]) bad++;
      check("ram_image", bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
